// File: rtl/spare_scan_ctrl.sv
// rtl/spare_scan_ctrl.sv - spare-cell scan chain load/capture/unload sequencer
module spare_scan_ctrl #(
    parameter int CHAIN_LEN = 10
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] mask,
    input  logic                 so,
    output logic                 scen,
    output logic                 si,
    output logic [CHAIN_LEN-1:0] tst_mode,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] capture_out
);

    localparam int CW = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, SHIFT1, CAPT, SHIFT2, FIN} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [1:0]           cmd_r, cmd_n;
    logic [CHAIN_LEN-1:0] pat_r, pat_n, mask_r, mask_n;
    logic                 shift_n, si_n, done_n;
    logic [CHAIN_LEN-1:0] tst_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cmd_n   = cmd_r;
        pat_n   = pat_r;
        mask_n  = mask_r;
        case (state)
            IDLE: begin
                if (start) begin
                    cmd_n  = cmd;
                    pat_n  = pattern;
                    mask_n = mask;
                    cnt_n  = '0;
                    case (cmd)
                        2'b00, 2'b10: state_n = SHIFT1;
                        2'b01:        state_n = CAPT;
                        default:      state_n = FIN;
                    endcase
                end
            end
            SHIFT1: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = (cmd_r == 2'b10) ? CAPT : FIN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CAPT:    state_n = (cmd_r == 2'b10) ? SHIFT2 : FIN;
            SHIFT2: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = FIN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        shift_n = (state_n == SHIFT1) || (state_n == SHIFT2);
        si_n    = shift_n ? pat_n[LAST - cnt_n] : 1'b0;
        tst_n   = (state_n == CAPT) ? mask_n : '0;
        done_n  = (state == FIN);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_r       <= '0;
            pat_r       <= '0;
            mask_r      <= '0;
            scen        <= 1'b0;
            si          <= 1'b0;
            tst_mode    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            capture_out <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cmd_r    <= cmd_n;
            pat_r    <= pat_n;
            mask_r   <= mask_n;
            scen     <= shift_n;
            si       <= si_n;
            tst_mode <= tst_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            // so is sampled on the same edge the chain shifts, yielding the old contents MSB first.
            if ((state == SHIFT1) || (state == SHIFT2)) begin
                capture_out <= {capture_out[CHAIN_LEN-2:0], so};
            end
        end
    end

endmodule

// File: tb/tb_spare_scan_ctrl.sv
// tb/tb_spare_scan_ctrl.sv - table-driven scoreboard bench for spare_scan_ctrl
module tb_spare_scan_ctrl;

    localparam int N = 10;

    logic         Clk, nReset, start, so, scen, si, busy, done;
    logic [1:0]   cmd;
    logic [N-1:0] pattern, mask, tst_mode, capture_out, func, chain;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [1:0]   cmd;
        logic [N-1:0] pattern;
        logic [N-1:0] mask;
        logic [N-1:0] func;
        logic [N-1:0] exp_cap;
        logic [N-1:0] exp_si;
        int           exp_done;
        int           exp_scen;
        int           exp_tst_cnt;
        logic [N-1:0] exp_tst;
    } vec_t;

    vec_t tbl[8];
    vec_t sb[$];

    spare_scan_ctrl #(.CHAIN_LEN(N)) dut (
        .Clk(Clk), .nReset(nReset), .start(start), .cmd(cmd), .pattern(pattern),
        .mask(mask), .so(so), .scen(scen), .si(si), .tst_mode(tst_mode),
        .busy(busy), .done(done), .capture_out(capture_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Spare chain: set/reset value 0x300, scan shift or masked functional load.
    always @(posedge Clk or negedge nReset) begin
        if (!nReset) chain <= 10'h300;
        else if (scen) chain <= {chain[N-2:0], si};
        else chain <= (chain & ~tst_mode) | (func & tst_mode);
    end
    assign so = chain[N-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_cmd(input vec_t v, input int poke, input bit hold);
        vec_t         e;
        int           dc, sc, tc, bc;
        logic [N-1:0] sw, tv;
        bit           seen;
        sb.push_back(v);
        @(posedge Clk); #1;
        start = 1'b1; cmd = v.cmd; pattern = v.pattern; mask = v.mask; func = v.func;
        @(posedge Clk); #1;
        if (!hold) begin
            start = 1'b0; cmd = 2'($urandom); pattern = N'($urandom); mask = N'($urandom);
        end
        dc = 0; sc = 0; tc = 0; bc = 0; sw = '0; tv = '0; seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (scen) begin sc++; sw = {sw[N-2:0], si}; end
            if (tst_mode != '0) begin tc++; tv = tst_mode; end
            if (busy) bc++;
            if (done) begin dc = c; seen = 1'b1; break; end
            if (poke != 0 && c == poke) begin start = 1'b1; cmd = 2'b01; mask = '1; end
            if (poke != 0 && c == poke + 1) start = 1'b0;
        end
        e = sb.pop_front();
        chk("done_seen", 32'(seen), 1);
        chk("done_cycle", dc, e.exp_done);
        chk("scen_cycles", sc, e.exp_scen);
        chk("si_word", sw, e.exp_si);
        chk("tst_cycles", tc, e.exp_tst_cnt);
        chk("tst_value", tv, e.exp_tst);
        chk("busy_cycles", bc, e.exp_done - 1);
        chk("capture_out", capture_out, e.exp_cap);
    endtask

    initial begin
        vec_t v;
        int   dc, bad;
        tbl[0] = '{2'b00, 10'h2A5, 10'h000, 10'h000, 10'h300, 10'h2A5, 12, 10, 0, 10'h000};
        tbl[1] = '{2'b00, 10'h155, 10'h000, 10'h000, 10'h2A5, 10'h155, 12, 10, 0, 10'h000};
        tbl[2] = '{2'b00, 10'h000, 10'h000, 10'h000, 10'h155, 10'h000, 12, 10, 0, 10'h000};
        tbl[3] = '{2'b01, 10'h000, 10'h0F0, 10'h3FF, 10'h155, 10'h000, 3, 0, 1, 10'h0F0};
        tbl[4] = '{2'b00, 10'h3FF, 10'h000, 10'h000, 10'h0F0, 10'h3FF, 12, 10, 0, 10'h000};
        tbl[5] = '{2'b10, 10'h1C3, 10'h3FF, 10'h05A, 10'h05A, 10'h1C3, 23, 20, 1, 10'h3FF};
        tbl[6] = '{2'b11, 10'h0AA, 10'h3FF, 10'h000, 10'h05A, 10'h000, 2, 0, 0, 10'h000};
        tbl[7] = '{2'b00, 10'h000, 10'h000, 10'h000, 10'h1C3, 10'h000, 12, 10, 0, 10'h000};

        nReset = 1'b0; start = 1'b0; cmd = '0; pattern = '0; mask = '0; func = '0;
        repeat (3) @(negedge Clk);
        chk("rst_scen", scen, 0);
        chk("rst_si", si, 0);
        chk("rst_tst_mode", tst_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_capture_out", capture_out, 0);
        nReset = 1'b1;

        for (int i = 0; i < 8; i++) run_cmd(tbl[i], 0, 1'b0);

        // start pulsed mid-shift must be ignored
        v = '{2'b00, 10'h2A5, 10'h000, 10'h000, 10'h000, 10'h2A5, 12, 10, 0, 10'h000};
        run_cmd(v, 5, 1'b0);
        bad = 0;
        repeat (4) begin
            @(negedge Clk);
            if (busy || done) bad++;
        end
        chk("ignored_start_idle", bad, 0);

        // start held through the done cycle is accepted there
        v = '{2'b00, 10'h155, 10'h000, 10'h000, 10'h2A5, 10'h155, 12, 10, 0, 10'h000};
        run_cmd(v, 0, 1'b1);
        chk("busy_in_done_cycle", busy, 0);
        @(negedge Clk);
        chk("busy_after_done_accept", busy, 1);
        chk("done_after_done_accept", done, 0);
        start = 1'b0;
        dc = 0;
        for (int c = 2; c <= 40; c++) begin
            @(negedge Clk);
            if (done) begin dc = c; break; end
        end
        chk("b2b_done_cycle", dc, 12);
        chk("b2b_capture_out", capture_out, 10'h155);

        // asynchronous reset during shift cycle 5
        @(posedge Clk); #1;
        start = 1'b1; cmd = 2'b00; pattern = 10'h3C3;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (5) @(negedge Clk);
        nReset = 1'b0;
        #1;
        chk("arst_scen", scen, 0);
        chk("arst_si", si, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tst_mode", tst_mode, 0);
        chk("arst_capture_out", capture_out, 0);
        @(negedge Clk);
        nReset = 1'b1;
        bad = 0;
        repeat (15) begin
            @(negedge Clk);
            if (busy || done || scen) bad++;
        end
        chk("arst_no_done", bad, 0);
        chk("arst_capture_hold", capture_out, 0);
        v = '{2'b00, 10'h001, 10'h000, 10'h000, 10'h300, 10'h001, 12, 10, 0, 10'h000};
        run_cmd(v, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
